// File: rtl/float_consts_pkg.sv
// Float constants and FSM state encoding shared by the SVPWM transform stages.
package float_consts_pkg;

    localparam logic [31:0] C_SQRT3_2 = 32'h3F5DB3D7;
    localparam logic [31:0] C_HALF    = 32'h3F000000;
    localparam logic [31:0] C_ZERO    = 32'h00000000;

    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MUL1  = 3'd1,
        S_ADD   = 3'd2,
        S_MUL2  = 3'd3,
        S_LATCH = 3'd4,
        S_DONE  = 3'd5
    } state_e;

endpackage

// File: rtl/svpwm_sector.sv
// SVPWM sector/reference-time stage: computes sector N and X/Y/Z from U_alpha/U_beta
// by sequencing operands through the shared external float multiplier and adder units.
module svpwm_sector
    import float_consts_pkg::*;
#(
    parameter int MUL_WAIT = 12,
    parameter int ADD_WAIT = 12
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [31:0] U_alpha,
    input  logic [31:0] U_beta,
    input  logic [31:0] K,
    input  logic [31:0] re_mult1,
    input  logic [31:0] re_mult2,
    input  logic [31:0] re_mult3,
    input  logic [31:0] re_add1,
    input  logic [31:0] re_add2,
    output logic [31:0] mult1a,
    output logic [31:0] mult1b,
    output logic [31:0] mult2a,
    output logic [31:0] mult2b,
    output logic [31:0] mult3a,
    output logic [31:0] mult3b,
    output logic [31:0] add1a,
    output logic [31:0] add1b,
    output logic [31:0] add2a,
    output logic [31:0] add2b,
    output logic        isadd1,
    output logic        isadd2,
    output logic [31:0] X,
    output logic [31:0] Y,
    output logic [31:0] Z,
    output logic [2:0]  sector,
    output logic        ack,
    output state_e      dbg_state_o
);

    localparam logic [CNT_W-1:0] MUL_END = CNT_W'(MUL_WAIT);
    localparam logic [CNT_W-1:0] ADD_END = CNT_W'(ADD_WAIT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Strictly negative: sign set and magnitude non-zero, so -0 counts as not negative.
    function automatic logic neg_nonzero(input logic [31:0] f);
        return f[31] && (f[30:0] != 31'd0);
    endfunction

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        m1a_q, m1a_d, m1b_q, m1b_d;
    logic [31:0]        m2a_q, m2a_d, m2b_q, m2b_d;
    logic [31:0]        m3a_q, m3a_d, m3b_q, m3b_d;
    logic [31:0]        a1a_q, a1a_d, a1b_q, a1b_d;
    logic [31:0]        a2a_q, a2a_d, a2b_q, a2b_d;
    logic               isadd1_q, isadd1_d, isadd2_q, isadd2_d;
    logic [31:0]        x_q, x_d, y_q, y_d, z_q, z_d;
    logic [2:0]         sector_q, sector_d;
    logic               bit_a_q, bit_a_d, bit_b_q, bit_b_d, bit_c_q, bit_c_d;

    logic               enter_mul1, enter_add, enter_mul2, do_latch;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (en) state_d = S_MUL1;
            S_MUL1:  if (cnt_q == MUL_END) state_d = S_ADD;
            S_ADD:   if (cnt_q == ADD_END) state_d = S_MUL2;
            S_MUL2:  if (cnt_q == MUL_END) state_d = S_LATCH;
            S_LATCH: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign cnt_d = ((state_d == state_q) && (state_q != S_IDLE)) ? cnt_q + CNT_ONE : '0;

    assign enter_mul1 = (state_q == S_IDLE)  && (state_d == S_MUL1);
    assign enter_add  = (state_q == S_MUL1)  && (state_d == S_ADD);
    assign enter_mul2 = (state_q == S_ADD)   && (state_d == S_MUL2);
    assign do_latch   = (state_q == S_LATCH);

    // Operand ports and results hold unless their own entry edge rewrites them.
    always_comb begin
        m1a_d    = m1a_q;
        m1b_d    = m1b_q;
        m2a_d    = m2a_q;
        m2b_d    = m2b_q;
        m3a_d    = m3a_q;
        m3b_d    = m3b_q;
        a1a_d    = a1a_q;
        a1b_d    = a1b_q;
        a2a_d    = a2a_q;
        a2b_d    = a2b_q;
        isadd1_d = isadd1_q;
        isadd2_d = isadd2_q;
        x_d      = x_q;
        y_d      = y_q;
        z_d      = z_q;
        sector_d = sector_q;
        bit_a_d  = bit_a_q;
        bit_b_d  = bit_b_q;
        bit_c_d  = bit_c_q;

        if (enter_mul1) begin
            m1a_d = C_SQRT3_2;
            m1b_d = U_alpha;
            m2a_d = C_HALF;
            m2b_d = U_beta;
            m3a_d = K;
            m3b_d = U_beta;
        end

        if (enter_add) begin
            a1a_d    = re_mult1;
            a1b_d    = re_mult2;
            isadd1_d = 1'b1;
            a2a_d    = re_mult2;
            a2b_d    = re_mult1;
            isadd2_d = 1'b0;
            x_d      = re_mult3;
            bit_a_d  = !U_beta[31] && (U_beta[30:0] != 31'd0);
        end

        if (enter_mul2) begin
            m1a_d   = K;
            m1b_d   = re_add1;
            m2a_d   = K;
            m2b_d   = re_add2;
            bit_b_d = neg_nonzero(re_add2);
            bit_c_d = neg_nonzero(re_add1);
        end

        if (do_latch) begin
            y_d      = re_mult1;
            z_d      = re_mult2;
            sector_d = {bit_c_q, bit_b_q, bit_a_q};
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            m1a_q    <= C_ZERO;
            m1b_q    <= C_ZERO;
            m2a_q    <= C_ZERO;
            m2b_q    <= C_ZERO;
            m3a_q    <= C_ZERO;
            m3b_q    <= C_ZERO;
            a1a_q    <= C_ZERO;
            a1b_q    <= C_ZERO;
            a2a_q    <= C_ZERO;
            a2b_q    <= C_ZERO;
            isadd1_q <= 1'b0;
            isadd2_q <= 1'b0;
            x_q      <= C_ZERO;
            y_q      <= C_ZERO;
            z_q      <= C_ZERO;
            sector_q <= 3'd0;
            bit_a_q  <= 1'b0;
            bit_b_q  <= 1'b0;
            bit_c_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            m1a_q    <= m1a_d;
            m1b_q    <= m1b_d;
            m2a_q    <= m2a_d;
            m2b_q    <= m2b_d;
            m3a_q    <= m3a_d;
            m3b_q    <= m3b_d;
            a1a_q    <= a1a_d;
            a1b_q    <= a1b_d;
            a2a_q    <= a2a_d;
            a2b_q    <= a2b_d;
            isadd1_q <= isadd1_d;
            isadd2_q <= isadd2_d;
            x_q      <= x_d;
            y_q      <= y_d;
            z_q      <= z_d;
            sector_q <= sector_d;
            bit_a_q  <= bit_a_d;
            bit_b_q  <= bit_b_d;
            bit_c_q  <= bit_c_d;
        end
    end

    assign mult1a      = m1a_q;
    assign mult1b      = m1b_q;
    assign mult2a      = m2a_q;
    assign mult2b      = m2b_q;
    assign mult3a      = m3a_q;
    assign mult3b      = m3b_q;
    assign add1a       = a1a_q;
    assign add1b       = a1b_q;
    assign add2a       = a2a_q;
    assign add2b       = a2b_q;
    assign isadd1      = isadd1_q;
    assign isadd2      = isadd2_q;
    assign X           = x_q;
    assign Y           = y_q;
    assign Z           = z_q;
    assign sector      = sector_q;
    assign ack         = (state_q == S_DONE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_svpwm_sector.sv
// Bench for svpwm_sector: models the shared float units, predicts {sector,X,Y,Z}
// from the sector/reference-time formulas and checks each ack against a queue.
module tb_svpwm_sector;
    import float_consts_pkg::*;

    localparam int W = 99;  // {sector[2:0], X, Y, Z}

    logic        sys_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic        en      = 1'b0;
    logic [31:0] U_alpha = '0, U_beta = '0, K = '0;
    logic [31:0] re_mult1 = '0, re_mult2 = '0, re_mult3 = '0;
    logic [31:0] re_add1 = '0, re_add2 = '0;
    logic [31:0] mult1a, mult1b, mult2a, mult2b, mult3a, mult3b;
    logic [31:0] add1a, add1b, add2a, add2b;
    logic        isadd1, isadd2, ack;
    logic [31:0] X, Y, Z;
    logic [2:0]  sector;
    state_e      dbg_state;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    svpwm_sector dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .en(en),
        .U_alpha(U_alpha), .U_beta(U_beta), .K(K),
        .re_mult1(re_mult1), .re_mult2(re_mult2), .re_mult3(re_mult3),
        .re_add1(re_add1), .re_add2(re_add2),
        .mult1a(mult1a), .mult1b(mult1b), .mult2a(mult2a), .mult2b(mult2b),
        .mult3a(mult3a), .mult3b(mult3b),
        .add1a(add1a), .add1b(add1b), .add2a(add2a), .add2b(add2b),
        .isadd1(isadd1), .isadd2(isadd2),
        .X(X), .Y(Y), .Z(Z), .sector(sector), .ack(ack),
        .dbg_state_o(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 sys_clk = ~sys_clk;

    // ---------------- float helpers ----------------
    function automatic real f32_to_real(input logic [31:0] f);
        logic [10:0] de;
        if (f[30:23] == 8'd0) return $bitstoreal({f[31], 63'd0});
        de = 11'(int'(f[30:23]) - 127 + 1023);
        return $bitstoreal({f[31], de, f[22:0], 29'd0});
    endfunction

    // Round a double to the nearest single (ties to even); tiny results flush to signed zero.
    function automatic logic [31:0] real_to_f32(input real r);
        logic [63:0] b;
        logic [23:0] m;
        logic [24:0] mr;
        logic [28:0] rem;
        int e;
        b = $realtobits(r);
        if (b[62:52] == 11'd0) return {b[63], 31'd0};
        e   = int'(b[62:52]) - 1023 + 127;
        m   = {1'b1, b[51:29]};
        rem = b[28:0];
        if (rem > 29'h10000000 || (rem == 29'h10000000 && m[0])) begin
            mr = {1'b0, m} + 25'd1;
            if (mr[24]) begin
                m = mr[24:1];
                e = e + 1;
            end else begin
                m = mr[23:0];
            end
        end
        if (e <= 0)   return {b[63], 31'd0};
        if (e >= 255) return {b[63], 8'hFF, 23'd0};
        return {b[63], e[7:0], m[22:0]};
    endfunction

    function automatic real rr(input real v);
        return f32_to_real(real_to_f32(v));
    endfunction

    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        return real_to_f32(f32_to_real(a) * f32_to_real(b));
    endfunction

    function automatic logic [31:0] faddsub(input logic [31:0] a, input logic [31:0] b, input logic add);
        return add ? real_to_f32(f32_to_real(a) + f32_to_real(b))
                   : real_to_f32(f32_to_real(a) - f32_to_real(b));
    endfunction

    // Shared external units: one-clock registered float multiply/add.
    always @(posedge sys_clk) begin
        re_mult1 <= fmul(mult1a, mult1b);
        re_mult2 <= fmul(mult2a, mult2b);
        re_mult3 <= fmul(mult3a, mult3b);
        re_add1  <= faddsub(add1a, add1b, isadd1);
        re_add2  <= faddsub(add2a, add2b, isadd2);
    end

    // Reference: every product and sum rounded to single, sector from the signs.
    function automatic logic [W-1:0] model(input logic [31:0] ua, input logic [31:0] ub, input logic [31:0] k);
        real s, a, b, kr, p1, p2, sum, dif;
        logic [2:0] n;
        s   = f32_to_real(32'h3F5DB3D7);
        a   = f32_to_real(ua);
        b   = f32_to_real(ub);
        kr  = f32_to_real(k);
        p1  = rr(s * a);
        p2  = rr(0.5 * b);
        sum = rr(p1 + p2);
        dif = rr(p2 - p1);
        n   = {sum < 0.0, dif < 0.0, b > 0.0};
        return {n, real_to_f32(kr * b), real_to_f32(kr * sum), real_to_f32(kr * dif)};
    endfunction

    function automatic logic [31:0] rand_f32(input int lo, input int hi);
        return real_to_f32(real'($urandom_range(hi - lo, 0) + lo) / 1000.0);
    endfunction

    // ---------------- scoreboard monitor ----------------
    logic ack_prev = 1'b0;
    always @(negedge sys_clk) begin
        logic [W-1:0] exp_v;
        if (ack_prev) begin
            checks++;
            if (ack) begin
                errors++;
                $display("FAIL ack_width: ack=%0b after previous ack cycle, required 0", ack);
            end
        end
        if (ack) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack: got sector=%0d X=%h Y=%h Z=%h, none required",
                         sector, X, Y, Z);
            end else begin
                exp_v = exp_q.pop_front();
                if ({sector, X, Y, Z} !== exp_v) begin
                    errors++;
                    $display("FAIL result: got sector=%0d X=%h Y=%h Z=%h, required sector=%0d X=%h Y=%h Z=%h",
                             sector, X, Y, Z, exp_v[98:96], exp_v[95:64], exp_v[63:32], exp_v[31:0]);
                end
            end
        end
        ack_prev = ack;
    end

    // ---------------- driver tasks ----------------
    task automatic check_reset_state(input string name);
        checks++;
        if ({mult1a, mult1b, mult2a, mult2b, mult3a, mult3b, add1a, add1b, add2a, add2b,
             isadd1, isadd2, X, Y, Z, sector, ack} !== '0) begin
            errors++;
            $display("FAIL %s_outputs: X=%h Y=%h Z=%h sector=%0d ack=%0b mult1a=%h add1a=%h, required all 0",
                     name, X, Y, Z, sector, ack, mult1a, add1a);
        end
        checks++;
        if (dbg_state !== S_IDLE) begin
            errors++;
            $display("FAIL %s_state: state=%0d, required IDLE(0)", name, dbg_state);
        end
    endtask

    // Latency counts rising edges from en assertion, the sampling edge being the first.
    task automatic run_one(input logic [31:0] ua, input logic [31:0] ub, input logic [31:0] k,
                           input logic [W-1:0] exp_v, input int pulse_a, input int pulse_b,
                           input int rst_at);
        int n;
        bit seen;
        @(negedge sys_clk);
        U_alpha = ua;
        U_beta  = ub;
        K       = k;
        en      = 1'b1;
        if (rst_at < 0) exp_q.push_back(exp_v);
        n    = 0;
        seen = 0;
        while (!seen && n < 200) begin
            @(posedge sys_clk);
            n++;
            @(negedge sys_clk);
            en = (n == pulse_a || n == pulse_b);
            if (n == rst_at) begin
                rst_n = 1'b0;
                #1;
                check_reset_state("midrun_reset");
                repeat (2) @(negedge sys_clk);
                rst_n = 1'b1;
                return;
            end
            if (ack) seen = 1;
        end
        checks++;
        if (!seen || n != 41) begin
            errors++;
            $display("FAIL latency: ack after %0d clocks (seen=%0b), required 41", n, seen);
        end
        en = 1'b0;
        repeat (3) @(negedge sys_clk);
    endtask

    task automatic run_held(input logic [31:0] ua, input logic [31:0] ub, input logic [31:0] k);
        int n, first, second;
        @(negedge sys_clk);
        U_alpha = ua;
        U_beta  = ub;
        K       = k;
        en      = 1'b1;
        exp_q.push_back(model(ua, ub, k));
        exp_q.push_back(model(ua, ub, k));
        n      = 0;
        first  = 0;
        second = 0;
        while (second == 0 && n < 300) begin
            @(posedge sys_clk);
            n++;
            @(negedge sys_clk);
            if (ack) begin
                if (first == 0) first = n;
                else begin
                    second = n;
                    en = 1'b0;
                end
            end
        end
        en = 1'b0;
        checks++;
        if (first != 41) begin
            errors++;
            $display("FAIL held_first_ack: at clock %0d, required 41", first);
        end
        checks++;
        if (second - first != 42) begin
            errors++;
            $display("FAIL held_ack_spacing: %0d clocks, required 42", second - first);
        end
        repeat (3) @(negedge sys_clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] ua, ub, k;
        repeat (2) @(negedge sys_clk);
        check_reset_state("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        run_one(32'h3F800000, 32'h00000000, 32'h3F800000,
                {3'd2, 32'h00000000, 32'h3F5DB3D7, 32'hBF5DB3D7}, -1, -1, -1);
        run_one(32'h00000000, 32'h3F800000, 32'h40000000,
                {3'd1, 32'h40000000, 32'h3F800000, 32'h3F800000}, -1, -1, -1);
        run_one(32'hBF800000, 32'h00000000, 32'h3F800000,
                {3'd4, 32'h00000000, 32'hBF5DB3D7, 32'h3F5DB3D7}, -1, -1, -1);
        run_one(32'h00000000, 32'h00000000, 32'h3F800000,
                {3'd0, 32'h00000000, 32'h00000000, 32'h00000000}, -1, -1, -1);
        run_one(32'h80000000, 32'h80000000, 32'h3FC00000,
                model(32'h80000000, 32'h80000000, 32'h3FC00000), -1, -1, -1);

        // en re-pulsed mid-run must be ignored
        run_one(32'h00000000, 32'h3F800000, 32'h40000000,
                {3'd1, 32'h40000000, 32'h3F800000, 32'h3F800000}, 5, 20, -1);

        run_held(rand_f32(-5000, 5000), rand_f32(-5000, 5000), rand_f32(100, 2000));

        ua = rand_f32(-5000, 5000);
        ub = rand_f32(-5000, 5000);
        k  = rand_f32(100, 2000);
        run_one(ua, ub, k, model(ua, ub, k), -1, -1, 20);
        repeat (2) @(negedge sys_clk);
        run_one(ua, ub, k, model(ua, ub, k), -1, -1, -1);

        for (int i = 0; i < 16; i++) begin
            ua = rand_f32(-10000, 10000);
            ub = rand_f32(-10000, 10000);
            k  = rand_f32(100, 2000);
            run_one(ua, ub, k, model(ua, ub, k), -1, -1, -1);
        end

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_acks: %0d results outstanding, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
